regfile_write_arbiter: RTL and testbench

//   Write-port controller for the 16 x 16-bit register set. Shares its single write port

---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the register-set write arbiter and its surroundings.
//   master : the requester/register-set side; drives req, reqAddr, reqData and clear,
//            and observes gnt, busy and the register-set write controls
//   slave  : the arbiter; consumes the requests and drives the grant and write controls
// Signals
//   req        NREQ      req[i]=1: requester i has a pending write
//   reqAddr    4*NREQ    target register of requester i, bits [4i+3:4i]
//   reqData    16*NREQ   write data of requester i, bits [16i+15:16i]
//   clear      1         one-cycle pulse that reruns the init sweep
//   gnt        NREQ      one-hot grant pulse
//   busy       1         init sweep in progress
//   regWrite   1         register-set write enable
//   decOut     16        one-hot register select
//   writeData  16        register-set write data
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [4*NREQ-1:0]    reqAddr;
  logic [16*NREQ-1:0]   reqData;
  logic                 clear;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 regWrite;
  logic [15:0]          decOut;
  logic [15:0]          writeData;

  modport master (
    output req, reqAddr, reqData, clear,
    input  gnt, busy, regWrite, decOut, writeData
  );

  modport slave (
    input  req, reqAddr, reqData, clear,
    output gnt, busy, regWrite, decOut, writeData
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 16 x 16-bit register set. The single write port is shared
// among NREQ requesters by round-robin arbitration, and after reset (or on clear) an init
// sweep writes INIT_VAL into R0..R15. All outputs are registered.
// Ports
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   bus    slave modport of regfile_write_arbiter_if (requests in, grant/write controls out)
module regfile_write_arbiter #(
  parameter int          NREQ     = 3,
  parameter logic [15:0] INIT_VAL = 16'h0000,
  parameter bit          DO_INIT  = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t          state_q;
  logic [3:0]      count_q;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            regWrite_q;
  logic [15:0]     decOut_q;
  logic [15:0]     writeData_q;

  logic [NREQ-1:0] elig_d;
  logic            winValid_d;
  logic [PW-1:0]   winIdx_d;
  logic [3:0]      winAddr_d;
  logic [15:0]     winData_d;

  // A request seen while its own grant is on the outputs was already taken this cycle,
  // so it is masked off. The winner is the first eligible index after the pointer,
  // wrapping at NREQ.
  always_comb begin
    int idx;
    idx        = 0;
    elig_d     = bus.req & ~gnt_q;
    winValid_d = 1'b0;
    winIdx_d   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!winValid_d && elig_d[PW'(idx)]) begin
        winValid_d = 1'b1;
        winIdx_d   = PW'(idx);
      end
    end
    winAddr_d = bus.reqAddr[{winIdx_d, 2'b00} +: 4];
    winData_d = bus.reqData[{winIdx_d, 4'b0000} +: 16];
  end

  // Controller FSM. INIT walks count_q over R0..R15 and leaves on the R15 write with busy
  // already low; IDLE serves one request per edge unless a clear restarts the sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DO_INIT ? ST_INIT : ST_IDLE;
      busy_q      <= DO_INIT;
      count_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      gnt_q       <= '0;
      regWrite_q  <= 1'b0;
      decOut_q    <= '0;
      writeData_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          gnt_q       <= '0;
          regWrite_q  <= 1'b1;
          decOut_q    <= 16'd1 << count_q;
          writeData_q <= INIT_VAL;
          count_q     <= count_q + 4'd1;
          if (count_q == 4'd15) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (bus.clear) begin
            state_q    <= ST_INIT;
            busy_q     <= 1'b1;
            count_q    <= '0;
            gnt_q      <= '0;
            regWrite_q <= 1'b0;
            decOut_q   <= '0;
          end else if (winValid_d) begin
            gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << winIdx_d;
            regWrite_q  <= 1'b1;
            decOut_q    <= 16'd1 << winAddr_d;
            writeData_q <= winData_d;
            ptr_q       <= winIdx_d;
          end else begin
            gnt_q      <= '0;
            regWrite_q <= 1'b0;
            decOut_q   <= '0;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.regWrite  = regWrite_q;
  assign bus.decOut    = decOut_q;
  assign bus.writeData = writeData_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NREQ=3, DO_INIT=1, INIT_VAL=0).
// A behavioural model predicts the outputs of every edge; the prediction is queued when the
// stimulus is applied and popped when the DUT outputs are sampled. A small register-set model
// captures the DUT writes so register contents can be compared with the expected contents.
module tb_regfile_write_arbiter;

  localparam int          NREQ     = 3;
  localparam logic [15:0] INIT_VAL = 16'h0000;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            regWrite;
    logic [15:0]     decOut;
    logic [15:0]     writeData;
  } outs_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_write_arbiter_if #(.NREQ(NREQ)) bus();

  regfile_write_arbiter #(
    .NREQ    (NREQ),
    .INIT_VAL(INIT_VAL),
    .DO_INIT (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  outs_t expQ[$];
  outs_t got;
  outs_t exp;

  logic [15:0] regs[16];
  logic [15:0] refRegs[16];

  logic       mInit;
  logic [3:0] mCount;
  int         mPtr;
  outs_t      mOut;

  // Register-set model: filled with a marker while reset is low so the sweep is visible.
  always @(posedge clk) begin
    for (int r = 0; r < 16; r++) begin
      if (!reset) regs[r] <= 16'hFFFF;
      else if (bus.regWrite && bus.decOut[r]) regs[r] <= bus.writeData;
    end
  end

  task automatic modelReset();
    mInit  = 1'b1;
    mCount = '0;
    mPtr   = NREQ - 1;
    mOut   = '{gnt: '0, busy: 1'b1, regWrite: 1'b0, decOut: '0, writeData: '0};
    expQ.delete();
  endtask

  task automatic modelStep();
    outs_t           n;
    logic [NREQ-1:0] elig;
    logic [3:0]      a;
    int              w;
    n = mOut;
    if (mInit) begin
      n.gnt             = '0;
      n.regWrite        = 1'b1;
      n.decOut          = 16'd1 << mCount;
      n.writeData       = INIT_VAL;
      refRegs[mCount]   = INIT_VAL;
      n.busy            = (mCount != 4'd15);
      if (mCount == 4'd15) mInit = 1'b0;
      mCount            = mCount + 4'd1;
    end else if (bus.clear) begin
      mInit      = 1'b1;
      mCount     = '0;
      n.busy     = 1'b1;
      n.gnt      = '0;
      n.regWrite = 1'b0;
      n.decOut   = '0;
    end else begin
      elig = bus.req & ~mOut.gnt;
      w    = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && elig[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
      if (w >= 0) begin
        a           = bus.reqAddr[4*w +: 4];
        n.gnt       = '0;
        n.gnt[w]    = 1'b1;
        n.regWrite  = 1'b1;
        n.decOut    = 16'd1 << a;
        n.writeData = bus.reqData[16*w +: 16];
        refRegs[a]  = bus.reqData[16*w +: 16];
        mPtr        = w;
      end else begin
        n.gnt      = '0;
        n.regWrite = 1'b0;
        n.decOut   = '0;
      end
    end
    mOut = n;
    expQ.push_back(n);
  endtask

  // Predict the next edge from the inputs currently driven, then advance one clock.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.reqAddr = '0; bus.reqData = '0; bus.clear = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
    exp = '{gnt: '0, busy: 1'b1, regWrite: 1'b0, decOut: '0, writeData: '0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h exp=%h", got, exp);
    end
    modelReset();
    reset = 1'b1;
    for (int c = 0; c < 17; c++) begin
      applyStimulus();
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL init_sweep cyc=%0d gnt=%b busy=%b rw=%b dec=%h wd=%h exp gnt=%b busy=%b rw=%b dec=%h wd=%h",
                 c, got.gnt, got.busy, got.regWrite, got.decOut, got.writeData,
                 exp.gnt, exp.busy, exp.regWrite, exp.decOut, exp.writeData);
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (regs[r] !== INIT_VAL) begin
        errors++;
        $display("[TB] FAIL init_reg R%0d got=%h exp=%h", r, regs[r], INIT_VAL);
      end
    end
  endtask

  task automatic test_single_write();
    bus.req = 3'b001; bus.reqAddr[3:0] = 4'd5; bus.reqData[15:0] = 16'hBEEF;
    for (int c = 0; c < 2; c++) begin
      applyStimulus();
      if (c == 0) bus.req = '0;
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL single_write cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
    checks++;
    if (regs[5] !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL single_write_R5 got=%h exp=%h", regs[5], 16'hBEEF);
    end
  endtask

  task automatic test_single_requester();
    bus.req = 3'b010; bus.reqAddr[7:4] = 4'd10; bus.reqData[31:16] = 16'h1110;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) bus.req = '0;
      applyStimulus();
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL single_requester cyc=%0d got=%h exp=%h", c, got, exp);
      end
      if (exp.gnt[1]) begin
        bus.reqAddr[7:4]   = bus.reqAddr[7:4] + 4'd1;
        bus.reqData[31:16] = bus.reqData[31:16] + 16'h0001;
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (regs[r] !== refRegs[r]) begin
        errors++;
        $display("[TB] FAIL single_requester_reg R%0d got=%h exp=%h", r, regs[r], refRegs[r]);
      end
    end
  endtask

  task automatic test_clear_priority();
    bus.clear = 1'b1;
    bus.req = 3'b100; bus.reqAddr[11:8] = 4'd9; bus.reqData[47:32] = 16'h1234;
    for (int c = 0; c < 19; c++) begin
      applyStimulus();
      bus.clear = 1'b0;
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      if (exp.gnt[2]) bus.req = '0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL clear_priority cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (regs[r] !== refRegs[r]) begin
        errors++;
        $display("[TB] FAIL clear_priority_reg R%0d got=%h exp=%h", r, regs[r], refRegs[r]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] nextAddr;
    nextAddr = 4'd4;
    bus.req = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      bus.reqAddr[4*i +: 4]  = 4'(i + 1);
      bus.reqData[16*i +: 16] = 16'hA000 + 16'(i + 1);
    end
    for (int c = 0; c < 7; c++) begin
      if (c == 6) bus.req = '0;
      applyStimulus();
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL round_robin cyc=%0d got=%h exp=%h", c, got, exp);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp.gnt[i]) begin
          bus.reqAddr[4*i +: 4]   = nextAddr;
          bus.reqData[16*i +: 16] = 16'hA000 + 16'(nextAddr);
          nextAddr                = nextAddr + 4'd1;
        end
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (regs[r] !== refRegs[r]) begin
        errors++;
        $display("[TB] FAIL round_robin_reg R%0d got=%h exp=%h", r, regs[r], refRegs[r]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bus.clear = 1'b1;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      bus.clear = 1'b0;
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL sweep_before_reset cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
    reset = 1'b0;
    #1;
    got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
    exp = '{gnt: '0, busy: 1'b1, regWrite: 1'b0, decOut: '0, writeData: '0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_mid_sweep got=%h exp=%h", got, exp);
    end
    modelReset();
    reset = 1'b1;
    for (int c = 0; c < 17; c++) begin
      applyStimulus();
      got = {bus.gnt, bus.busy, bus.regWrite, bus.decOut, bus.writeData};
      exp = expQ.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL sweep_after_reset cyc=%0d got=%h exp=%h", c, got, exp);
      end
    end
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (regs[r] !== INIT_VAL) begin
        errors++;
        $display("[TB] FAIL restart_reg R%0d got=%h exp=%h", r, regs[r], INIT_VAL);
      end
    end
  endtask

  // Scenarios run in this order so that requester 2 holds the pointer before the
  // all-requesters case, which then starts its rotation at requester 0.
  initial begin
    test_reset();
    test_single_write();
    test_single_requester();
    test_clear_priority();
    test_round_robin();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
